fifo_wr_arbiter: RTL and testbench

- Shares the write port of one FIFO instance among NREQ requesters.
- Round-robin arbitration with burst lock: the current owner keeps the port for up to MAX_BURST accepted words, then must give it up.
- Drives the FIFO's write enable and write data, and honours the FIFO full flag.
- Sits between the producer blocks and the FIFO write side, in the same clock domain.

---
 rtl/fifo_wr_arbiter_pkg.sv | 16 +
 rtl/fifo_wr_arbiter_if.sv | 30 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 105 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and the
// default geometry that the FIFO wrapper also uses.
package fifo_wr_arbiter_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_OWN_BIT   = 2;
  localparam int DEF_MAX_BURST = 8;
  localparam int DEF_BURST_BIT = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side request lanes plus FIFO write-side signals of the arbiter.
// "master" is the arbiter view; "slave" is the producers/FIFO view.
interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREQ    = DEF_NREQ,
  parameter int OWN_BIT = DEF_OWN_BIT
);

  logic [NREQ-1:0]       i_req;
  logic [NREQ*WIDTH-1:0] i_data;
  logic                  i_full;
  logic [NREQ-1:0]       o_ack;
  logic                  o_wen;
  logic [WIDTH-1:0]      o_data;
  logic [OWN_BIT-1:0]    o_owner;
  logic                  o_busy;

  modport master (
    input  i_req, i_data, i_full,
    output o_ack, o_wen, o_data, o_owner, o_busy
  );

  modport slave (
    output i_req, i_data, i_full,
    input  o_ack, o_wen, o_data, o_owner, o_busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester with req=1,
// searching upward from (last+1) with wrap-around.
module fifo_wr_arbiter_rr_pick #(
  parameter int NREQ    = 4,
  parameter int OWN_BIT = 2
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWN_BIT-1:0] last,
  output logic [OWN_BIT-1:0] next_idx,
  output logic               any_valid
);

  logic [NREQ-1:0] shifted;
  int              idx;

  always_comb begin
    next_idx  = '0;
    any_valid = 1'b0;
    shifted   = '0;
    idx       = 0;
    // Scan from the farthest offset to the nearest so the nearest hit wins.
    for (int ofs = NREQ; ofs >= 1; ofs--) begin
      idx     = (int'(last) + ofs) % NREQ;
      shifted = req >> idx;
      if (shifted[0]) begin
        next_idx  = OWN_BIT'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with burst lock sharing one FIFO write port among NREQ
// producers; writes are issued in the same cycle as the producer ack.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NREQ      = DEF_NREQ,
  parameter int OWN_BIT   = DEF_OWN_BIT,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int BURST_BIT = DEF_BURST_BIT
) (
  input  logic               i_clk,
  input  logic               i_rest,
  fifo_wr_arbiter_if.master  bus
);

  localparam logic [BURST_BIT-1:0] LAST_BEAT = BURST_BIT'(MAX_BURST - 1);

  arb_state_t           state_reg, state_next;
  logic [OWN_BIT-1:0]   owner_reg, owner_next;
  logic [OWN_BIT-1:0]   last_reg, last_next;
  logic [BURST_BIT-1:0] burst_cnt_reg, burst_cnt_next;

  logic [OWN_BIT-1:0]   pick_idx;
  logic                 pick_valid;
  logic [NREQ-1:0]      owner_onehot;
  logic                 own_req;
  logic                 accept;

  logic [WIDTH-1:0]     lane_masked [NREQ];
  logic [WIDTH-1:0]     lane_acc    [NREQ+1];

  fifo_wr_arbiter_rr_pick #(
    .NREQ    (NREQ),
    .OWN_BIT (OWN_BIT)
  ) u_rr_pick (
    .req       (bus.i_req),
    .last      (last_reg),
    .next_idx  (pick_idx),
    .any_valid (pick_valid)
  );

  // Owner decode and an AND-OR mux of the owner's data lane.
  assign lane_acc[0] = '0;
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign owner_onehot[gi]  = (owner_reg == OWN_BIT'(gi));
    assign lane_masked[gi]   = owner_onehot[gi] ? bus.i_data[gi*WIDTH +: WIDTH] : '0;
    assign lane_acc[gi+1]    = lane_acc[gi] | lane_masked[gi];
    assign bus.o_ack[gi]     = accept & owner_onehot[gi];
  end

  assign own_req = |(bus.i_req & owner_onehot);

  always_ff @(posedge i_clk or negedge i_rest) begin
    if (!i_rest) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= '0;
      last_reg      <= OWN_BIT'(NREQ - 1);
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      last_reg      <= last_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    last_next      = last_reg;
    burst_cnt_next = burst_cnt_reg;
    accept         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_next     = pick_idx;
          burst_cnt_next = '0;
          state_next     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        accept = own_req & ~bus.i_full;
        if (!own_req) begin
          // Owner released: nothing is written this cycle.
          state_next = ST_IDLE;
          last_next  = owner_reg;
        end else if (accept) begin
          burst_cnt_next = burst_cnt_reg + 1'b1;
          if (burst_cnt_reg == LAST_BEAT) begin
            state_next = ST_IDLE;
            last_next  = owner_reg;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.o_wen   = accept;
  assign bus.o_data  = accept ? lane_acc[NREQ] : '0;
  assign bus.o_owner = owner_reg;
  assign bus.o_busy  = (state_reg == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner
// sequences and random traffic against a behavioural grant/scoreboard model.
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int WIDTH     = 8;
  localparam int NREQ      = 4;
  localparam int OWN_BIT   = 2;
  localparam int MAX_BURST = 8;
  localparam int BURST_BIT = 4;
  localparam int NVEC      = 14;

  logic i_clk  = 1'b0;
  logic i_rest = 1'b0;
  always #5 i_clk = ~i_clk;

  fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .OWN_BIT(OWN_BIT)) bus ();

  logic [WIDTH-1:0] lane [NREQ];
  assign bus.i_data = {lane[3], lane[2], lane[1], lane[0]};

  fifo_wr_arbiter #(
    .WIDTH(WIDTH), .NREQ(NREQ), .OWN_BIT(OWN_BIT),
    .MAX_BURST(MAX_BURST), .BURST_BIT(BURST_BIT)
  ) dut (
    .i_clk  (i_clk),
    .i_rest (i_rest),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic [3:0] ack;
    logic       wen;
    logic [7:0] data;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ack, input logic wen,
                         input logic [7:0] data, input logic [1:0] owner, input logic busy);
    check({tag, ".ack"},   32'(bus.o_ack),   32'(ack));
    check({tag, ".wen"},   32'(bus.o_wen),   32'(wen));
    check({tag, ".data"},  32'(bus.o_data),  32'(data));
    check({tag, ".owner"}, 32'(bus.o_owner), 32'(owner));
    check({tag, ".busy"},  32'(bus.o_busy),  32'(busy));
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rest     = 1'b0;
    bus.i_req  = '0;
    bus.i_full = 1'b0;
    repeat (2) @(posedge i_clk);
    #3 i_rest = 1'b1;
  endtask

  task automatic set_lanes();
    for (int k = 0; k < NREQ; k++) lane[k[1:0]] = 8'hA0 + 8'(k);
  endtask

  function automatic logic bit_of(input logic [NREQ-1:0] v, input int k);
    logic [NREQ-1:0] t;
    t = v >> k;
    return t[0];
  endfunction

  // Reference round-robin choice: first requester after 'last', wrapping.
  function automatic logic [1:0] rr_next(input logic [NREQ-1:0] r, input logic [1:0] last);
    for (int d = 1; d <= NREQ; d++)
      if (bit_of(r, (int'(last) + d) % NREQ)) return 2'((int'(last) + d) % NREQ);
    return 2'd0;
  endfunction

  // Random-phase state.
  logic [3:0] req_v, prev_req_v, prev_ack, exp_ack;
  logic       full_v, m_busy, dut_prev_busy;
  logic [1:0] m_owner, m_last, go;
  logic [7:0] exp_data, e;
  logic [4:0] seq [NREQ];
  int         m_words, m_total, writes;
  int         wait_g [NREQ];
  int         exp_next [8];
  logic [7:0] fifo_q [$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req  = '0;
    bus.i_full = 1'b0;
    set_lanes();

    // ---------------- vector table: release after 2 words, next goes to 3
    vecs[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[1]  = '{4'b0010, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[2]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b1};
    vecs[3]  = '{4'b0010, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b1};
    vecs[4]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b1};
    vecs[5]  = '{4'b1000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b1};
    vecs[6]  = '{4'b1000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0};
    vecs[7]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 8'hA3, 2'd3, 1'b1};
    vecs[8]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b1};
    vecs[9]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd3, 1'b0};
    vecs[10] = '{4'b0001, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1};
    vecs[11] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1};
    vecs[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b1};
    vecs[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};

    do_reset();
    #1;
    chk_out("reset", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    for (int i = 0; i < NVEC; i++) begin
      tick();
      bus.i_req  = vecs[i].req;
      bus.i_full = vecs[i].full;
      #1;
      $display("vec %0d req=%b full=%b ack=%b owner=%0d busy=%b",
               i, vecs[i].req, vecs[i].full, bus.o_ack, bus.o_owner, bus.o_busy);
      chk_out($sformatf("vec%0d", i), vecs[i].ack, vecs[i].wen, vecs[i].data,
              vecs[i].owner, vecs[i].busy);
    end

    // ---------------- single requester: burst of 8, 1-cycle gap, re-grant
    do_reset();
    tick();
    lane[0]   = 8'h10;
    bus.i_req = 4'b0001;
    #1;
    chk_out("t1.idle0", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    for (int i = 0; i < MAX_BURST; i++) begin
      tick();
      if (i > 0) lane[0] = lane[0] + 8'd1;
      #1;
      chk_out($sformatf("t1.w%0d", i), 4'b0001, 1'b1, 8'h10 + 8'(i), 2'd0, 1'b1);
    end
    tick();
    lane[0] = lane[0] + 8'd1;
    #1;
    chk_out("t1.gap", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    tick();
    #1;
    chk_out("t1.regrant", 4'b0001, 1'b1, 8'h18, 2'd0, 1'b1);
    $display("t1 single-requester burst done");

    // ---------------- all requesting: grant order 0,1,2,3,0
    set_lanes();
    do_reset();
    tick();
    bus.i_req = 4'b1111;
    #1;
    chk_out("t2.idle", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    for (int g = 0; g < 5; g++) begin
      logic [1:0] o;
      o = 2'(g % NREQ);
      for (int w = 0; w < MAX_BURST; w++) begin
        tick();
        #1;
        chk_out($sformatf("t2.g%0d.w%0d", g, w), 4'b0001 << o, 1'b1, 8'hA0 + 8'(o), o, 1'b1);
      end
      tick();
      #1;
      chk_out($sformatf("t2.g%0d.gap", g), 4'b0000, 1'b0, 8'h00, o, 1'b0);
      $display("t2 grant %0d owner=%0d", g, o);
    end

    // ---------------- full stall mid-burst for requester 2
    do_reset();
    tick();
    bus.i_req = 4'b0100;
    #1;
    chk_out("t3.idle", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    writes = 0;
    for (int c = 0; c < MAX_BURST + 5; c++) begin
      tick();
      bus.i_full = (c >= 3 && c < 8);
      #1;
      if (bus.i_full) chk_out($sformatf("t3.c%0d", c), 4'b0000, 1'b0, 8'h00, 2'd2, 1'b1);
      else            chk_out($sformatf("t3.c%0d", c), 4'b0100, 1'b1, 8'hA2, 2'd2, 1'b1);
      if (bus.o_wen) writes++;
    end
    tick();
    bus.i_full = 1'b0;
    #1;
    chk_out("t3.end", 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0);
    check("t3.burst_words", 32'(writes), 32'(MAX_BURST));
    $display("t3 stalled burst words=%0d", writes);

    // ---------------- asynchronous reset mid-burst, restart from requester 0
    do_reset();
    tick();
    bus.i_req = 4'b1000;
    #1;
    chk_out("t5.idle", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk_out($sformatf("t5.w%0d", i), 4'b1000, 1'b1, 8'hA3, 2'd3, 1'b1);
    end
    tick();
    #1;
    i_rest = 1'b0;
    #1;
    chk_out("t5.async", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge i_clk);
    i_rest = 1'b1;
    #1;
    chk_out("t5.released", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    tick();
    #1;
    chk_out("t5.regrant", 4'b1000, 1'b1, 8'hA3, 2'd3, 1'b1);
    $display("t5 reset mid-burst done");

    // ---------------- random traffic against the reference model
    do_reset();
    req_v = '0; prev_req_v = '0; prev_ack = '0;
    m_busy = 1'b0; m_owner = 2'd0; m_last = 2'(NREQ - 1);
    m_words = 0; m_total = 0; dut_prev_busy = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      seq[k[1:0]] = '0;
      wait_g[k[1:0]] = 0;
    end
    for (int k = 0; k < 8; k++) exp_next[k[2:0]] = 0;

    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      // Producers: advance after an ack, hold data while waiting.
      for (int k = 0; k < NREQ; k++) begin
        if (bit_of(prev_ack, k)) begin
          seq[k[1:0]] = seq[k[1:0]] + 5'd1;
          if ($urandom_range(3) == 0) req_v = req_v & ~(4'b0001 << k);
        end else if (!bit_of(req_v, k) && $urandom_range(2) == 0) begin
          req_v = req_v | (4'b0001 << k);
        end
        lane[k[1:0]] = {3'(k), seq[k[1:0]]};
      end
      full_v     = ($urandom_range(3) == 0);
      bus.i_req  = req_v;
      bus.i_full = full_v;
      #1;

      exp_ack  = '0;
      exp_data = '0;
      if (m_busy && bit_of(req_v, int'(m_owner)) && !full_v) begin
        exp_ack  = 4'b0001 << m_owner;
        exp_data = lane[m_owner];
      end
      check("rnd.ack",    32'(bus.o_ack),   32'(exp_ack));
      check("rnd.wen",    32'(bus.o_wen),   32'(exp_ack != 4'b0000));
      check("rnd.data",   32'(bus.o_data),  32'(exp_data));
      check("rnd.owner",  32'(bus.o_owner), 32'(m_owner));
      check("rnd.busy",   32'(bus.o_busy),  32'(m_busy));
      check("rnd.onehot", 32'($countones(bus.o_ack) <= 1), 32'd1);

      // Fairness measured on the DUT's own grant events.
      if (bus.o_busy && !dut_prev_busy) begin
        go = bus.o_owner;
        check("rnd.fair", 32'(wait_g[go] <= NREQ - 1), 32'd1);
        for (int k = 0; k < NREQ; k++) begin
          if (k[1:0] == go)              wait_g[k[1:0]] = 0;
          else if (bit_of(prev_req_v, k)) wait_g[k[1:0]] = wait_g[k[1:0]] + 1;
          else                            wait_g[k[1:0]] = 0;
        end
        $display("rnd grant owner=%0d t=%0t", go, $time);
      end
      dut_prev_busy = bus.o_busy;
      prev_req_v    = req_v;
      prev_ack      = bus.o_ack;
      if (bus.o_wen) fifo_q.push_back(bus.o_data);

      // Model of the grant lifecycle for the next cycle.
      if (!m_busy) begin
        if (req_v != 4'b0000) begin
          m_owner = rr_next(req_v, m_last);
          m_busy  = 1'b1;
          m_words = 0;
        end
      end else if (!bit_of(req_v, int'(m_owner))) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end else if (!full_v) begin
        m_words++;
        m_total++;
        if (m_words == MAX_BURST) begin
          m_busy = 1'b0;
          m_last = m_owner;
        end
      end
    end

    // Scoreboard: FIFO holds each requester's words in order, none lost.
    check("rnd.fifo_count", 32'(fifo_q.size()), 32'(m_total));
    foreach (fifo_q[i]) begin
      e = fifo_q[i];
      check("rnd.fifo_order", 32'(e[4:0]), 32'(exp_next[e[7:5]] % 32));
      exp_next[e[7:5]] = exp_next[e[7:5]] + 1;
    end
    $display("rnd words written=%0d", fifo_q.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
